// File: rtl/mem_wb_stage_pkg.sv
// Shared defines for the MEM/WB pipeline slice: reset/enable levels, stall-bit
// indices, default widths, and the per-edge WB register action decode.
package mem_wb_stage_pkg;

  localparam int REG_W_DEF      = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int STALL_W        = 6;
  localparam int STALL_MEM      = 4;
  localparam int STALL_WB       = 5;

  localparam logic        RstEnable    = 1'b0;
  localparam logic        RstDisable   = 1'b1;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  typedef enum logic [1:0] {
    WB_BUBBLE  = 2'd0,
    WB_ADVANCE = 2'd1,
    WB_HOLD    = 2'd2
  } wb_action_e;

  // Flush beats every stall value; MEM advancing with WB stalled is illegal
  // and is simply treated as an advance.
  function automatic wb_action_e wb_action(input logic flush, input logic mem_stall,
                                           input logic wb_stall);
    if (flush)
      return WB_BUBBLE;
    else if (!mem_stall)
      return WB_ADVANCE;
    else if (!wb_stall)
      return WB_BUBBLE;
    else
      return WB_HOLD;
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// HI/LO special registers; the value written by the instruction sitting in WB
// is forwarded straight to the outputs during that cycle.
module hilo_reg
  import mem_wb_stage_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [REG_W-1:0] hi,
  input  logic [REG_W-1:0] lo,
  output logic [REG_W-1:0] hi_o,
  output logic [REG_W-1:0] lo_o
);

  logic [REG_W-1:0] hi_reg;
  logic [REG_W-1:0] lo_reg;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (we == WriteEnable) begin
      hi_reg <= hi;
      lo_reg <= lo;
    end
  end

  assign hi_o = (we == WriteEnable) ? hi : hi_reg;
  assign lo_o = (we == WriteEnable) ? lo : lo_reg;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with bubble/hold/flush control, retired-instruction
// counter, and the HI/LO register block fed from the WB slot.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int REG_W      = REG_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [REG_W-1:0]      mem_wdata,
  input  logic                  mem_whilo,
  input  logic [REG_W-1:0]      mem_hi,
  input  logic [REG_W-1:0]      mem_lo,
  output logic [REG_ADDR_W-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [REG_W-1:0]      wb_wdata,
  output logic [REG_W-1:0]      hi_o,
  output logic [REG_W-1:0]      lo_o,
  output logic [31:0]           retire_cnt
);

  wb_action_e action;

  logic [REG_ADDR_W-1:0] wd_reg,    wd_next;
  logic                  wreg_reg,  wreg_next;
  logic [REG_W-1:0]      wdata_reg, wdata_next;
  logic                  whilo_reg, whilo_next;
  logic [REG_W-1:0]      hi_reg,    hi_next;
  logic [REG_W-1:0]      lo_reg,    lo_next;
  logic                  valid_reg, valid_next;
  logic [31:0]           retire_cnt_reg;

  // Only the MEM and WB stall bits matter to this stage.
  logic stall_unused;
  assign stall_unused = ^stall[STALL_MEM-1:0];

  assign action = wb_action(flush, stall[STALL_MEM], stall[STALL_WB]);

  always_comb begin
    wd_next    = wd_reg;
    wreg_next  = wreg_reg;
    wdata_next = wdata_reg;
    whilo_next = whilo_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    valid_next = valid_reg;
    unique case (action)
      WB_BUBBLE: begin
        wd_next    = '0;
        wreg_next  = WriteDisable;
        wdata_next = '0;
        whilo_next = WriteDisable;
        hi_next    = '0;
        lo_next    = '0;
        valid_next = 1'b0;
      end
      WB_ADVANCE: begin
        wd_next    = mem_wd;
        wreg_next  = mem_wreg;
        wdata_next = mem_wdata;
        whilo_next = mem_whilo;
        hi_next    = mem_hi;
        lo_next    = mem_lo;
        valid_next = mem_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wd_reg    <= '0;
      wreg_reg  <= WriteDisable;
      wdata_reg <= '0;
      whilo_reg <= WriteDisable;
      hi_reg    <= '0;
      lo_reg    <= '0;
      valid_reg <= 1'b0;
    end else begin
      wd_reg    <= wd_next;
      wreg_reg  <= wreg_next;
      wdata_reg <= wdata_next;
      whilo_reg <= whilo_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      valid_reg <= valid_next;
    end
  end

  // Retirement depends only on the slot leaving WB, so a flush of the
  // incoming instruction never cancels it.
  always_ff @(posedge clk) begin
    if (rst == RstEnable)
      retire_cnt_reg <= ZeroWord;
    else if (valid_reg && !stall[STALL_WB])
      retire_cnt_reg <= retire_cnt_reg + 32'd1;
  end

  hilo_reg #(
    .REG_W(REG_W)
  ) u_hilo_reg (
    .clk  (clk),
    .rst  (rst),
    .we   (whilo_reg),
    .hi   (hi_reg),
    .lo   (lo_reg),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

  assign wb_wd      = wd_reg;
  assign wb_wreg    = wreg_reg;
  assign wb_wdata   = wdata_reg;
  assign retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, advance, stall/hold, flush, HI/LO
// forwarding, counter wrap and reset during a hold.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        mem_valid;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] retire_cnt;

  int passed = 0;
  int total  = 0;

  mem_wb_stage #(
    .REG_W(32),
    .REG_ADDR_W(5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .mem_valid  (mem_valid),
    .mem_wd     (mem_wd),
    .mem_wreg   (mem_wreg),
    .mem_wdata  (mem_wdata),
    .mem_whilo  (mem_whilo),
    .mem_hi     (mem_hi),
    .mem_lo     (mem_lo),
    .wb_wd      (wb_wd),
    .wb_wreg    (wb_wreg),
    .wb_wdata   (wb_wdata),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic whilo,
                         input logic [31:0] hi, input logic [31:0] lo);
    mem_valid = v;
    mem_wd    = wd;
    mem_wreg  = wreg;
    mem_wdata = wdata;
    mem_whilo = whilo;
    mem_hi    = hi;
    mem_lo    = lo;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b1; stall = 6'b110000;
    set_mem(1'b1, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF, 32'hEEEE);
    tick();
    total++; if (wb_wd !== 5'd0) $display("FAIL rst_wd: got %0d want 0", wb_wd); else passed++;
    total++; if (wb_wreg !== 1'b0) $display("FAIL rst_wreg: got %0b want 0", wb_wreg); else passed++;
    total++; if (wb_wdata !== 32'h0) $display("FAIL rst_wdata: got %h want 0", wb_wdata); else passed++;
    total++; if (hi_o !== 32'h0) $display("FAIL rst_hi: got %h want 0", hi_o); else passed++;
    total++; if (lo_o !== 32'h0) $display("FAIL rst_lo: got %h want 0", lo_o); else passed++;
    total++; if (retire_cnt !== 32'h0) $display("FAIL rst_cnt: got %h want 0", retire_cnt); else passed++;
    $display("reset: wd=%0d wreg=%0b wdata=%h cnt=%0d", wb_wd, wb_wreg, wb_wdata, retire_cnt);
    rst = 1'b1; flush = 1'b0; stall = 6'b000000;
    set_mem(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_advance();
    set_mem(1'b1, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0);
    tick();
    total++; if (wb_wd !== 5'd5) $display("FAIL adv_wd: got %0d want 5", wb_wd); else passed++;
    total++; if (wb_wreg !== 1'b1) $display("FAIL adv_wreg: got %0b want 1", wb_wreg); else passed++;
    total++; if (wb_wdata !== 32'hDEAD_BEEF) $display("FAIL adv_wdata: got %h want deadbeef", wb_wdata); else passed++;
    total++; if (retire_cnt !== 32'd0) $display("FAIL adv_cnt0: got %0d want 0", retire_cnt); else passed++;
    $display("advance: wd=%0d wreg=%0b wdata=%h cnt=%0d", wb_wd, wb_wreg, wb_wdata, retire_cnt);
    set_mem(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    total++; if (retire_cnt !== 32'd1) $display("FAIL adv_cnt1: got %0d want 1", retire_cnt); else passed++;
    total++; if (wb_wreg !== 1'b0) $display("FAIL adv_bubble_wreg: got %0b want 0", wb_wreg); else passed++;
    $display("advance retire: cnt=%0d", retire_cnt);
  endtask

  task automatic test_stall();
    stall = 6'b010000;
    set_mem(1'b1, 5'd7, 1'b1, 32'h1111_1111, 1'b0, 32'h0, 32'h0);
    tick();
    total++; if (wb_wreg !== 1'b0) $display("FAIL bub_wreg: got %0b want 0", wb_wreg); else passed++;
    total++; if (wb_wdata !== 32'h0) $display("FAIL bub_wdata: got %h want 0", wb_wdata); else passed++;
    total++; if (retire_cnt !== 32'd1) $display("FAIL bub_cnt: got %0d want 1", retire_cnt); else passed++;
    $display("bubble: wreg=%0b wdata=%h cnt=%0d", wb_wreg, wb_wdata, retire_cnt);
    tick();
    total++; if (retire_cnt !== 32'd1) $display("FAIL bub_cnt2: got %0d want 1", retire_cnt); else passed++;
    stall = 6'b000000;
    tick();
    total++; if (wb_wd !== 5'd7) $display("FAIL ld_wd: got %0d want 7", wb_wd); else passed++;
    stall = 6'b110000;
    set_mem(1'b1, 5'd8, 1'b1, 32'h2222_2222, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (wb_wd !== 5'd7) $display("FAIL hold_wd[%0d]: got %0d want 7", i, wb_wd); else passed++;
      total++; if (wb_wreg !== 1'b1) $display("FAIL hold_wreg[%0d]: got %0b want 1", i, wb_wreg); else passed++;
      total++; if (wb_wdata !== 32'h1111_1111) $display("FAIL hold_wdata[%0d]: got %h want 11111111", i, wb_wdata); else passed++;
      total++; if (retire_cnt !== 32'd1) $display("FAIL hold_cnt[%0d]: got %0d want 1", i, retire_cnt); else passed++;
      $display("hold %0d: wd=%0d wdata=%h cnt=%0d", i, wb_wd, wb_wdata, retire_cnt);
    end
    stall = 6'b000000;
    set_mem(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    total++; if (retire_cnt !== 32'd2) $display("FAIL release_cnt: got %0d want 2", retire_cnt); else passed++;
    total++; if (wb_wd !== 5'd0) $display("FAIL release_wd: got %0d want 0", wb_wd); else passed++;
  endtask

  task automatic test_flush();
    set_mem(1'b1, 5'd9, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0);
    tick();
    flush = 1'b1; stall = 6'b110000;
    set_mem(1'b1, 5'd10, 1'b1, 32'h3333_3333, 1'b0, 32'h0, 32'h0);
    tick();
    total++; if (wb_wd !== 5'd0) $display("FAIL fl_wd: got %0d want 0", wb_wd); else passed++;
    total++; if (wb_wreg !== 1'b0) $display("FAIL fl_wreg: got %0b want 0", wb_wreg); else passed++;
    total++; if (wb_wdata !== 32'h0) $display("FAIL fl_wdata: got %h want 0", wb_wdata); else passed++;
    total++; if (retire_cnt !== 32'd2) $display("FAIL fl_cnt: got %0d want 2", retire_cnt); else passed++;
    $display("flush+hold: wd=%0d wreg=%0b wdata=%h cnt=%0d", wb_wd, wb_wreg, wb_wdata, retire_cnt);
    flush = 1'b0; stall = 6'b000000;
    set_mem(1'b1, 5'd11, 1'b1, 32'h4444_4444, 1'b0, 32'h0, 32'h0);
    tick();
    total++; if (wb_wd !== 5'd11) $display("FAIL fl_ld_wd: got %0d want 11", wb_wd); else passed++;
    flush = 1'b1;
    set_mem(1'b1, 5'd12, 1'b1, 32'h5555_5555, 1'b0, 32'h0, 32'h0);
    tick();
    total++; if (wb_wdata !== 32'h0) $display("FAIL fl2_wdata: got %h want 0", wb_wdata); else passed++;
    total++; if (retire_cnt !== 32'd3) $display("FAIL fl2_cnt: got %0d want 3", retire_cnt); else passed++;
    $display("flush retire: wdata=%h cnt=%0d", wb_wdata, retire_cnt);
    flush = 1'b0;
  endtask

  task automatic test_hilo();
    set_mem(1'b1, 5'd0, 1'b1, 32'h0000_00AA, 1'b1, 32'h1234, 32'h5678);
    tick();
    total++; if (wb_wd !== 5'd0) $display("FAIL r0_wd: got %0d want 0", wb_wd); else passed++;
    total++; if (wb_wreg !== 1'b1) $display("FAIL r0_wreg: got %0b want 1", wb_wreg); else passed++;
    total++; if (wb_wdata !== 32'hAA) $display("FAIL r0_wdata: got %h want aa", wb_wdata); else passed++;
    total++; if (hi_o !== 32'h1234) $display("FAIL fwd_hi: got %h want 1234", hi_o); else passed++;
    total++; if (lo_o !== 32'h5678) $display("FAIL fwd_lo: got %h want 5678", lo_o); else passed++;
    $display("hilo fwd: hi=%h lo=%h", hi_o, lo_o);
    set_mem(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    total++; if (hi_o !== 32'h1234) $display("FAIL st_hi: got %h want 1234", hi_o); else passed++;
    total++; if (lo_o !== 32'h5678) $display("FAIL st_lo: got %h want 5678", lo_o); else passed++;
    total++; if (retire_cnt !== 32'd4) $display("FAIL hilo_cnt: got %0d want 4", retire_cnt); else passed++;
    $display("hilo stored: hi=%h lo=%h cnt=%0d", hi_o, lo_o, retire_cnt);
    set_mem(1'b1, 5'd3, 1'b0, 32'h0, 1'b1, 32'hAAAA, 32'hBBBB);
    tick();
    total++; if (hi_o !== 32'hAAAA) $display("FAIL fwd2_hi: got %h want aaaa", hi_o); else passed++;
    flush = 1'b1;
    set_mem(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    total++; if (hi_o !== 32'hAAAA) $display("FAIL flhi_hi: got %h want aaaa", hi_o); else passed++;
    total++; if (lo_o !== 32'hBBBB) $display("FAIL flhi_lo: got %h want bbbb", lo_o); else passed++;
    total++; if (retire_cnt !== 32'd5) $display("FAIL flhi_cnt: got %0d want 5", retire_cnt); else passed++;
    $display("flush keeps hilo: hi=%h lo=%h cnt=%0d", hi_o, lo_o, retire_cnt);
    flush = 1'b0;
  endtask

  task automatic test_wrap();
    force dut.retire_cnt_reg = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_reg;
    total++; if (retire_cnt !== 32'hFFFF_FFFF) $display("FAIL wrap_pre: got %h want ffffffff", retire_cnt); else passed++;
    set_mem(1'b1, 5'd13, 1'b1, 32'h55, 1'b0, 32'h0, 32'h0);
    tick();
    total++; if (retire_cnt !== 32'hFFFF_FFFF) $display("FAIL wrap_mid: got %h want ffffffff", retire_cnt); else passed++;
    set_mem(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    total++; if (retire_cnt !== 32'h0) $display("FAIL wrap: got %h want 0", retire_cnt); else passed++;
    $display("wrap: cnt=%h", retire_cnt);
  endtask

  task automatic test_reset_midhold();
    set_mem(1'b1, 5'd14, 1'b1, 32'h6666_6666, 1'b1, 32'h99, 32'h77);
    tick();
    stall = 6'b110000;
    tick();
    total++; if (wb_wd !== 5'd14) $display("FAIL mh_hold_wd: got %0d want 14", wb_wd); else passed++;
    rst = 1'b0;
    tick();
    total++; if (wb_wd !== 5'd0) $display("FAIL mh_wd: got %0d want 0", wb_wd); else passed++;
    total++; if (wb_wreg !== 1'b0) $display("FAIL mh_wreg: got %0b want 0", wb_wreg); else passed++;
    total++; if (wb_wdata !== 32'h0) $display("FAIL mh_wdata: got %h want 0", wb_wdata); else passed++;
    total++; if (hi_o !== 32'h0) $display("FAIL mh_hi: got %h want 0", hi_o); else passed++;
    total++; if (lo_o !== 32'h0) $display("FAIL mh_lo: got %h want 0", lo_o); else passed++;
    total++; if (retire_cnt !== 32'h0) $display("FAIL mh_cnt: got %h want 0", retire_cnt); else passed++;
    $display("reset mid-hold: wd=%0d hi=%h lo=%h cnt=%0d", wb_wd, hi_o, lo_o, retire_cnt);
    rst = 1'b1;
    set_mem(1'b1, 5'd15, 1'b1, 32'h7777_7777, 1'b0, 32'h0, 32'h0);
    tick();
    total++; if (wb_wd !== 5'd0) $display("FAIL mh_still_wd: got %0d want 0", wb_wd); else passed++;
    stall = 6'b000000;
    tick();
    total++; if (wb_wd !== 5'd15) $display("FAIL mh_cap_wd: got %0d want 15", wb_wd); else passed++;
    total++; if (wb_wdata !== 32'h7777_7777) $display("FAIL mh_cap_wdata: got %h want 77777777", wb_wdata); else passed++;
    total++; if (retire_cnt !== 32'h0) $display("FAIL mh_cap_cnt: got %h want 0", retire_cnt); else passed++;
    $display("post-reset capture: wd=%0d wdata=%h cnt=%0d", wb_wd, wb_wdata, retire_cnt);
  endtask

  initial begin
    rst = 1'b0; stall = 6'b0; flush = 1'b0;
    set_mem(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_advance();
    test_stall();
    test_flush();
    test_hilo();
    test_wrap();
    test_reset_midhold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter REG_W, 32, data width of GPR, HI and LO values.
REQ-002 Parameter REG_ADDR_W, 5, GPR address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; one clock, reset synchronous and active-low.
REQ-005 stall  in  6  pipeline stall vector; bit 4 is the MEM stage, bit 5 is the WB stage.
REQ-006 flush  in  1  exception flush; squashes the instruction entering WB.
REQ-007 mem_valid  in  1  MEM-stage slot holds a real instruction, not a bubble.
REQ-008 mem_wd  in  REG_ADDR_W  GPR destination address.
REQ-009 mem_wreg  in  1  GPR write enable.
REQ-010 mem_wdata  in  REG_W  GPR write data.
REQ-011 mem_whilo, mem_hi, mem_lo  in  1/REG_W/REG_W  HI/LO write enable and data.
REQ-012 wb_wd, wb_wreg, wb_wdata  out  REG_ADDR_W/1/REG_W  registered GPR write port; drives the register file waddr/we/wdata.
REQ-013 hi_o, lo_o  out  REG_W each  current HI/LO values, with forwarding of the pending write.
REQ-014 retire_cnt  out  32  count of retired instructions.

Function
REQ-015 Latency SHALL be exactly one cycle from MEM inputs to wb_* outputs; all wb_* outputs are registers.
REQ-016 Priority at each edge SHALL be: reset > flush > bubble > advance > hold.
REQ-017 Bubble: flush=1, or stall[4]=1 with stall[5]=0, SHALL load wb_wd=0, wb_wreg=0, wb_wdata=0, wb_whilo=0, wb_hi=0, wb_lo=0, valid=0.
REQ-018 Advance: stall[4]=0 with flush=0 SHALL capture all mem_* inputs, including mem_valid, into the WB register.
REQ-019 Hold: stall[4]=1 and stall[5]=1 with flush=0 SHALL leave every WB register unchanged.
REQ-020 stall[4]=0 with stall[5]=1 is illegal; the block SHALL treat it as advance.
REQ-021 mem_wd=0 with mem_wreg=1 SHALL pass through unchanged; the register file discards writes to GPR 0.
REQ-022 HI/LO state: each edge with wb_whilo=1 SHALL store hi<=wb_hi and lo<=wb_lo; otherwise the stored values hold.
REQ-023 hi_o/lo_o SHALL be combinational: wb_hi/wb_lo when wb_whilo=1, else the stored HI/LO.
REQ-024 retire_cnt SHALL increment by 1 on each edge where the WB slot is valid and is not held (stall[5]=0). It wraps 0xFFFFFFFF->0 and does not increment on bubbles or flushed slots.
REQ-025 A flush together with any stall value SHALL produce a bubble. A flush does not cancel a HI/LO or retire_cnt update caused by the instruction already in WB that edge.

Reset
REQ-026 When rst=0 at a rising edge, all wb_* outputs, the valid bit, HI, LO and retire_cnt SHALL be 0 after that edge, regardless of flush or stall.
REQ-027 A reset asserted mid-hold SHALL discard the held instruction. After rst returns to 1, the first edge with stall[4]=0 captures the MEM inputs.

Structure
REQ-028 RstEnable (1'b0), WriteEnable, ZeroWord, the stall-bit indices and the REG_W and REG_ADDR_W defaults SHALL live in the shared defines package.
REQ-029 HI/LO storage and forwarding SHALL be one sub-module, hilo_reg, instantiated once. The pipeline register and retire counter stay in mem_wb_stage.

Verification
REQ-030 Advance: mem_wd=5, mem_wreg=1, mem_wdata=0xDEADBEEF, mem_valid=1, stall=0 -> next cycle wb_wd=5, wb_wreg=1, wb_wdata=0xDEADBEEF; one edge later retire_cnt=1.
REQ-031 Stall boundary: stall=6'b010000 -> wb_wreg=0, wb_wdata=0, retire_cnt unchanged. stall=6'b110000 for 3 cycles -> wb_* hold their prior values for all 3 cycles.
REQ-032 Flush priority: flush=1 with stall=6'b110000 and a valid instruction on the mem_* inputs -> next cycle all wb_* are 0.
REQ-033 HI/LO forwarding: mem_whilo=1, mem_hi=0x1234, mem_lo=0x5678 -> in the WB cycle hi_o=0x1234 and lo_o=0x5678 combinationally, and they remain after wb_whilo drops.
REQ-034 Wrap: preload retire_cnt to 0xFFFFFFFF via a forced/backdoor write, then retire 1 valid instruction -> retire_cnt=0.
REQ-035 Reset mid-hold: hold an instruction with stall=6'b110000, drive rst=0 for 1 cycle -> every output is 0, including retire_cnt, hi_o and lo_o.
